uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares the single UART transmitter among N requesters (debug console, status reporter, command responder, and so on). Each requester offers a byte stream framed into packets by a last flag. The arbiter grants one requester at a time, round-robin, and keeps the grant until that requester's last byte has been handed to the UART. It drives the transmitter's txdin/txgo pair from registers and paces itself on txrdy. A gap timeout stops a stalled requester from holding the UART indefinitely.

Parameters:
N, 4, number of requesters (2..8)
GAPW, 16, width of gap timeout counter
GAP_MAX, 50000, idle cycles allowed mid-packet before forced release (1 ms at 50 MHz)

Ports:
clk  in  1  main clock, same clock as the UART
rst  in  1  synchronous reset, active-high
req_valid  in  N  requester i has a byte on req_data
req_data  in  8*N  byte for requester i in bits [8i+7:8i]
req_last  in  N  byte from requester i is the last of its packet
req_ready  out  N  byte from requester i accepted this cycle when valid&ready
txdin  out  8  byte to UART, registered
txgo  out  1  one-cycle load strobe to UART, registered
txrdy  in  1  UART transmitter ready (high when idle or in stop bit)
grant  out  N  one-hot owner of the UART, all zero when idle
busy  out  1  packet in progress (state != IDLE)
timeout_err  out  1  one-cycle pulse on forced release

Behaviour:
- Reset: state=IDLE, grant=0, txdin=0x00, txgo=0, req_ready=0, timeout_err=0, gap=0, rr pointer=N-1, so requester 0 has priority first.
- IDLE:
  - If any req_valid is set, pick the first valid index searching from pointer+1 with wrap.
  - Register grant (one-hot) and set pointer to the winner.
  - Go to SEND on the next edge. Arbitration latency is 1 cycle.
- SEND:
  - req_ready[g] = txrdy. Other ready bits are 0.
  - On req_valid[g]&txrdy: txdin<=req_data[g], last_r<=req_last[g], gap<=0, go to GO.
  - On !req_valid[g]&txrdy: gap increments. When gap==GAP_MAX-1, pulse timeout_err, clear grant, go to IDLE. The partial packet is abandoned.
  - While txrdy=0 (UART shifting), gap holds.
- GO:
  - txgo=1 for exactly one cycle, with txdin stable.
  - Next state is IDLE (grant cleared) if last_r, otherwise SEND.
  - The UART drops txrdy on the edge that ends GO, so the next SEND cycle sees txrdy=0 and waits. No extra hold state is needed.
- Throughput: the UART dominates. Arbiter overhead is 2 cycles per byte and at most 1 cycle of idle between packets.
- Grant is never changed mid-packet except by timeout or rst.
- The granted requester dropping valid mid-packet is legal until the timeout fires.
- A requester whose valid is low in IDLE is skipped. There is no reservation.
- Simultaneous valid from all N is served strictly round-robin.
- Reset mid-packet:
  - Outputs return to reset values on the next edge.
  - A byte already strobed continues in the UART, which has its own reset behaviour.
- busy = (state != IDLE).
- grant is decoded from a binary index register.
- State encoding: IDLE=2'b00, SEND=2'b01, GO=2'b10. 2'b11 returns to IDLE.

Decomposition:
- Shared package: state localparams (IDLE/SEND/GO), default GAP_MAX values for 50 MHz (1 ms; a short value such as 20 for simulation).
- Sub-module rr_pick:
  - Combinational round-robin search.
  - Inputs: req[N-1:0], ptr index.
  - Outputs: any, idx.
  - Instantiated once.

Test Plan:
- Single packet: requester 0 sends 0x41,0x42,0x43(last), UART model holds txrdy low 10 bit-times after each txgo → three txgo pulses with txdin 0x41/0x42/0x43, grant=0001 throughout, busy falls 1 cycle after the third GO.
- Contention: requesters 1 and 2 both valid in the same cycle with 2-byte packets after reset → requester 1 packet completes fully, then requester 2; the UART byte stream is never interleaved.
- Fairness: all four requesters continuously valid with 1-byte packets → grant order 0,1,2,3,0,1…
- UART busy at grant: txrdy=0 when SEND entered → req_ready stays 0 and no txgo until txrdy=1; gap does not advance.
- Timeout (GAP_MAX=20): requester 3 sends a non-last byte then drops valid → timeout_err pulses exactly once, 20 txrdy-high cycles later; grant goes to 0; a pending requester 0 wins on the next arbitration.
- Reset mid-packet: assert rst during GO of byte 2 of 4 → next cycle txgo=0, grant=0, busy=0; after release, a fresh request is served from requester 0.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg
//   Shared definitions for the UART transmit arbiter.
//   - arb_state_t   : arbiter FSM encoding (IDLE/SEND/GO; 2'b11 is recovered to IDLE)
//   - GAP_MAX_50MHZ : mid-packet idle limit of 1 ms at a 50 MHz clock
//   - GAP_MAX_SIM   : short idle limit for simulation
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEND = 2'b01,
    GO   = 2'b10
  } arb_state_t;

  localparam int GAP_MAX_50MHZ = 50000;
  localparam int GAP_MAX_SIM   = 20;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin search. It scans req starting at ptr+1 and
//   wraps, returning the first set index.
//   Ports:
//     req [N-1:0]  request vector
//     ptr [IW-1:0] index of the previous winner
//     any          at least one request is set
//     idx [IW-1:0] winning index (0 when any is low)
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [IW-1:0] idx
);

  int          cand_s;
  logic [IW-1:0] cand_idx_s;

  // first set request after ptr, wrapping modulo N; ptr itself is checked last
  always_comb begin
    any        = 1'b0;
    idx        = {IW{1'b0}};
    cand_s     = 0;
    cand_idx_s = {IW{1'b0}};
    for (int i = 1; i <= N; i++) begin
      cand_s = int'(ptr) + i;
      if (cand_s >= N) begin
        cand_s = cand_s - N;
      end else begin
        cand_s = cand_s;
      end
      cand_idx_s = IW'(cand_s);
      if (!any && req[cand_idx_s]) begin
        any = 1'b1;
        idx = cand_idx_s;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmitter among N packet requesters, using round-robin
//   arbitration. A grant is held until the owner's last byte has been strobed
//   into the UART. It can also end when the owner leaves the UART idle for
//   GAP_MAX ready cycles mid-packet.
//   Ports:
//     clk, rst     clock and synchronous active-high reset
//     req_valid    per-requester byte valid
//     req_data     per-requester byte, requester i in [8i+7:8i]
//     req_last     per-requester end-of-packet flag
//     req_ready    per-requester accept (valid&ready = byte taken)
//     txdin, txgo  registered byte and one-cycle load strobe to the UART
//     txrdy        UART ready for a new byte
//     grant        one-hot current owner, zero when idle
//     busy         packet in progress
//     timeout_err  one-cycle pulse when a stalled owner is released
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N       = 4,
  parameter int GAPW    = 16,
  parameter int GAP_MAX = GAP_MAX_50MHZ
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_valid,
  input  logic [8*N-1:0] req_data,
  input  logic [N-1:0]   req_last,
  output logic [N-1:0]   req_ready,
  output logic [7:0]     txdin,
  output logic           txgo,
  input  logic           txrdy,
  output logic [N-1:0]   grant,
  output logic           busy,
  output logic           timeout_err
);

  localparam int              IW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [GAPW-1:0] GAP_LAST = GAPW'(GAP_MAX - 1);

  arb_state_t      state_r, state_nxt_s;
  logic [IW-1:0]   gnt_idx_r, gnt_idx_nxt_s;
  logic [IW-1:0]   ptr_r, ptr_nxt_s;
  logic [GAPW-1:0] gap_r, gap_nxt_s;
  logic            last_r, last_nxt_s;
  logic [7:0]      txdin_r, txdin_nxt_s;
  logic            txgo_r, txgo_nxt_s;
  logic            timeout_r, timeout_nxt_s;
  logic            pick_any_s;
  logic [IW-1:0]   pick_idx_s;
  logic [7:0]      own_byte_s;
  logic [N-1:0]    req_ready_s;
  logic [N-1:0]    grant_s;

  rr_pick #(.N(N), .IW(IW)) u_rr_pick (
    .req (req_valid),
    .ptr (ptr_r),
    .any (pick_any_s),
    .idx (pick_idx_s)
  );

  assign own_byte_s = req_data[{gnt_idx_r, 3'b000} +: 8];

  // next-state and handshake logic
  always_comb begin
    state_nxt_s   = state_r;
    gnt_idx_nxt_s = gnt_idx_r;
    ptr_nxt_s     = ptr_r;
    gap_nxt_s     = gap_r;
    last_nxt_s    = last_r;
    txdin_nxt_s   = txdin_r;
    txgo_nxt_s    = 1'b0;
    timeout_nxt_s = 1'b0;
    req_ready_s   = {N{1'b0}};
    case (state_r)
      IDLE: begin
        if (pick_any_s) begin
          state_nxt_s   = SEND;
          gnt_idx_nxt_s = pick_idx_s;
          ptr_nxt_s     = pick_idx_s;
          gap_nxt_s     = {GAPW{1'b0}};
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SEND: begin
        req_ready_s[gnt_idx_r] = txrdy;
        // the gap only counts cycles where the UART could have taken a byte
        if (txrdy) begin
          if (req_valid[gnt_idx_r]) begin
            txdin_nxt_s = own_byte_s;
            last_nxt_s  = req_last[gnt_idx_r];
            gap_nxt_s   = {GAPW{1'b0}};
            txgo_nxt_s  = 1'b1;
            state_nxt_s = GO;
          end else if (gap_r == GAP_LAST) begin
            timeout_nxt_s = 1'b1;
            gap_nxt_s     = {GAPW{1'b0}};
            state_nxt_s   = IDLE;
          end else begin
            gap_nxt_s = gap_r + GAPW'(1);
          end
        end else begin
          gap_nxt_s = gap_r;
        end
      end
      GO: begin
        // the UART drops txrdy on the edge that ends GO, so SEND waits by itself
        if (last_r) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = SEND;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // grant is the decoded owner index, masked while idle
  always_comb begin
    if (state_r != IDLE) begin
      grant_s = {{(N-1){1'b0}}, 1'b1} << gnt_idx_r;
    end else begin
      grant_s = {N{1'b0}};
    end
  end

  // arbiter state and registered UART outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      gnt_idx_r <= {IW{1'b0}};
      ptr_r     <= IW'(N - 1);
      gap_r     <= {GAPW{1'b0}};
      last_r    <= 1'b0;
      txdin_r   <= 8'h00;
      txgo_r    <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      gnt_idx_r <= gnt_idx_nxt_s;
      ptr_r     <= ptr_nxt_s;
      gap_r     <= gap_nxt_s;
      last_r    <= last_nxt_s;
      txdin_r   <= txdin_nxt_s;
      txgo_r    <= txgo_nxt_s;
      timeout_r <= timeout_nxt_s;
    end
  end

  assign req_ready   = req_ready_s;
  assign grant       = grant_s;
  assign busy        = (state_r != IDLE);
  assign txdin       = txdin_r;
  assign txgo        = txgo_r;
  assign timeout_err = timeout_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//   Directed bench for uart_tx_arbiter with four requesters. It uses a UART
//   model that holds txrdy low for 10 cycles after every txgo, and a
//   per-requester byte queue.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int GAP = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req_valid = 4'h0;
  logic [8*N-1:0] req_data = 32'h0;
  logic [N-1:0]  req_last = 4'h0;
  logic [N-1:0]  req_ready;
  logic [7:0]    txdin;
  logic          txgo;
  logic          txrdy;
  logic [N-1:0]  grant;
  logic          busy;
  logic          timeout_err;

  logic [3:0]    uart_cnt_r = 4'd0;
  logic          hold_low = 1'b0;
  logic [8:0]    q [N][$];
  logic [N-1:0]  acc;
  int            tests = 0;
  int            fails = 0;
  int            tmo_cnt = 0;

  uart_tx_arbiter #(.N(N), .GAPW(16), .GAP_MAX(GAP)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .txdin(txdin), .txgo(txgo),
    .txrdy(txrdy), .grant(grant), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // UART model: busy for 10 cycles after each load strobe
  assign txrdy = (uart_cnt_r == 4'd0) && !hold_low;
  always @(posedge clk) begin
    if (txgo) uart_cnt_r <= 4'd10;
    else if (uart_cnt_r != 4'd0) uart_cnt_r <= uart_cnt_r - 4'd1;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    logic [8:0] h;
    for (int i = 0; i < N; i++) begin
      if (q[i].size() != 0) begin
        h = q[i][0];
        req_valid[i] = 1'b1;
        req_data[8*i +: 8] = h[7:0];
        req_last[i] = h[8];
      end else begin
        req_valid[i] = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i] = 1'b0;
      end
    end
  endtask

  task automatic push(input int r, input logic [7:0] b, input logic l);
    q[r].push_back({l, b});
    refresh();
  endtask

  // one clock: note accepted bytes at the edge, pop them, land on the negedge
  task automatic tick();
    @(posedge clk);
    acc = rst ? 4'h0 : (req_valid & req_ready);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i] && q[i].size() != 0) void'(q[i].pop_front());
    end
    refresh();
    @(negedge clk);
    if (timeout_err) tmo_cnt++;
  endtask

  task automatic wait_txgo(input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!txgo && n < 300);
    check_val({tag, "_txgo_seen"}, {31'd0, txgo}, 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < N; i++) q[i].delete();
    refresh();
    rst = 1'b0;
    repeat (12) tick();
  endtask

  initial begin
    logic [7:0] eb;
    logic [3:0] eg;
    int bad;
    int n;
    int tmo_base;

    // reset state
    repeat (2) tick();
    check_val("rst_grant", {28'd0, grant}, 32'h0);
    check_val("rst_txgo", {31'd0, txgo}, 32'h0);
    check_val("rst_txdin", {24'd0, txdin}, 32'h0);
    check_val("rst_busy", {31'd0, busy}, 32'h0);
    check_val("rst_tmo", {31'd0, timeout_err}, 32'h0);
    check_val("rst_ready", {28'd0, req_ready}, 32'h0);
    do_reset();

    // single packet from requester 0
    push(0, 8'h41, 1'b0); push(0, 8'h42, 1'b0); push(0, 8'h43, 1'b1);
    for (int k = 0; k < 3; k++) begin
      wait_txgo("t1");
      eb = 8'h41 + 8'(k);
      check_val("t1_byte", {24'd0, txdin}, {24'd0, eb});
      check_val("t1_grant", {28'd0, grant}, 32'h1);
    end
    tick();
    check_val("t1_busy_after", {31'd0, busy}, 32'h0);
    check_val("t1_grant_after", {28'd0, grant}, 32'h0);
    check_val("t1_txgo_1cyc", {31'd0, txgo}, 32'h0);

    // contention between requesters 1 and 2
    do_reset();
    push(1, 8'h11, 1'b0); push(1, 8'h12, 1'b1);
    push(2, 8'h21, 1'b0); push(2, 8'h22, 1'b1);
    for (int k = 0; k < 4; k++) begin
      wait_txgo("t2");
      eb = (k < 2) ? (8'h11 + 8'(k)) : (8'h21 + 8'(k - 2));
      eg = (k < 2) ? 4'b0010 : 4'b0100;
      check_val("t2_byte", {24'd0, txdin}, {24'd0, eb});
      check_val("t2_grant", {28'd0, grant}, {28'd0, eg});
    end

    // fairness with all four continuously valid
    do_reset();
    for (int i = 0; i < N; i++) begin
      push(i, 8'hA0 + 8'(i), 1'b1);
      push(i, 8'hB0 + 8'(i), 1'b1);
    end
    for (int k = 0; k < 8; k++) begin
      wait_txgo("t3");
      eb = ((k < 4) ? 8'hA0 : 8'hB0) + 8'(k % 4);
      eg = 4'b0001 << (k % 4);
      check_val("t3_byte", {24'd0, txdin}, {24'd0, eb});
      check_val("t3_grant", {28'd0, grant}, {28'd0, eg});
    end

    // UART busy when SEND is entered
    do_reset();
    tmo_base = tmo_cnt;
    hold_low = 1'b1;
    push(2, 8'h5A, 1'b1);
    bad = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (req_ready != 4'h0 || txgo) bad++;
    end
    check_val("t4_no_handshake", bad, 32'd0);
    check_val("t4_busy_held", {31'd0, busy}, 32'h1);
    check_val("t4_grant_held", {28'd0, grant}, 32'h4);
    hold_low = 1'b0;
    #1;
    check_val("t4_ready_on_rdy", {28'd0, req_ready}, 32'h4);
    wait_txgo("t4");
    check_val("t4_byte", {24'd0, txdin}, 32'h5A);
    check_val("t4_no_timeout", tmo_cnt - tmo_base, 32'd0);

    // gap timeout on requester 3
    do_reset();
    tmo_base = tmo_cnt;
    push(3, 8'h77, 1'b0);
    wait_txgo("t5");
    check_val("t5_byte", {24'd0, txdin}, 32'h77);
    check_val("t5_grant", {28'd0, grant}, 32'h8);
    push(0, 8'h99, 1'b1);
    n = 0;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (timeout_err) break;
      if (busy && txrdy && !txgo) n++;
    end
    check_val("t5_tmo_seen", {31'd0, timeout_err}, 32'h1);
    check_val("t5_gap_cycles", n, GAP);
    check_val("t5_grant_released", {28'd0, grant}, 32'h0);
    tick();
    check_val("t5_tmo_one_cycle", {31'd0, timeout_err}, 32'h0);
    check_val("t5_next_grant", {28'd0, grant}, 32'h1);
    wait_txgo("t5b");
    check_val("t5_next_byte", {24'd0, txdin}, 32'h99);
    check_val("t5_tmo_count", tmo_cnt - tmo_base, 32'd1);

    // reset during GO of byte 2 of 4
    do_reset();
    push(1, 8'h31, 1'b0); push(1, 8'h32, 1'b0); push(1, 8'h33, 1'b0); push(1, 8'h34, 1'b1);
    wait_txgo("t6a");
    check_val("t6_byte1", {24'd0, txdin}, 32'h31);
    wait_txgo("t6b");
    check_val("t6_byte2", {24'd0, txdin}, 32'h32);
    rst = 1'b1;
    tick();
    check_val("t6_txgo_rst", {31'd0, txgo}, 32'h0);
    check_val("t6_grant_rst", {28'd0, grant}, 32'h0);
    check_val("t6_busy_rst", {31'd0, busy}, 32'h0);
    do_reset();
    push(0, 8'h66, 1'b1); push(1, 8'h67, 1'b1); push(3, 8'h68, 1'b1);
    for (int k = 0; k < 3; k++) begin
      wait_txgo("t6c");
      eb = (k == 0) ? 8'h66 : ((k == 1) ? 8'h67 : 8'h68);
      eg = (k == 0) ? 4'b0001 : ((k == 1) ? 4'b0010 : 4'b1000);
      check_val("t6_fresh_byte", {24'd0, txdin}, {24'd0, eb});
      check_val("t6_fresh_grant", {28'd0, grant}, {28'd0, eg});
    end
    check_val("total_timeouts", tmo_cnt, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
